alu_wide_seq: RTL

ALU_WIDE_SEQ -- requirements
Module: alu_wide_seq

---
 rtl/alu_wide_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences 16-bit wide operations over an external 8-bit ALU.
// Each legal request runs two ALU steps, one per byte. The carry is chained
// from step 1 to step 2. Right shifts work from the high byte down; every
// other operation works from the low byte up.
module alu_wide_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_c,
  output logic [4:0]  alu_inst,
  output logic [15:0] alu_op0,
  output logic [15:0] alu_op1,
  output logic        alu_c_in,
  input  logic [15:0] alu_result,
  input  logic        alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_c,
  output logic        rsp_z,
  output logic        rsp_n,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP1 = 2'd1;
  localparam logic [1:0] S_STEP2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADDW = 4'd0,  OP_ADCW = 4'd1,  OP_SUBW = 4'd2;
  localparam logic [3:0] OP_SBCW = 4'd3,  OP_ANDW = 4'd4,  OP_ORW  = 4'd5;
  localparam logic [3:0] OP_XORW = 4'd6,  OP_SRLW = 4'd7,  OP_SLLW = 4'd8;
  localparam logic [3:0] OP_RRCW = 4'd9,  OP_RLCW = 4'd10, OP_INCW = 4'd11;
  localparam logic [3:0] OP_DECW = 4'd12;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_ADC = 5'd1, ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_SBC = 5'd3, ALU_AND = 5'd4, ALU_OR  = 5'd5;
  localparam logic [4:0] ALU_XOR = 5'd6, ALU_SRL = 5'd7, ALU_SLL = 5'd8;
  localparam logic [4:0] ALU_RRC = 5'd9, ALU_RLC = 5'd10, ALU_PASS0 = 5'd15;

  logic [1:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        chain_c_q, chain_c_d;
  logic [15:0] res_q, res_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        err_q, err_d;

  logic        is_step2, shift_r, is_shift, is_logic, use_req_c, sel_hi;
  logic [7:0]  a_byte, b_byte;
  logic [4:0]  step_inst;
  logic        step_cin;
  logic [15:0] merged_res;

  // Decode which byte, ALU instruction and carry-in the current step uses
  always_comb begin
    is_step2  = (state_q == S_STEP2);
    shift_r   = (op_q == OP_SRLW) || (op_q == OP_RRCW);
    is_shift  = shift_r || (op_q == OP_SLLW) || (op_q == OP_RLCW);
    is_logic  = (op_q == OP_ANDW) || (op_q == OP_ORW) || (op_q == OP_XORW);
    use_req_c = (op_q == OP_ADCW) || (op_q == OP_SBCW) ||
                (op_q == OP_RLCW) || (op_q == OP_RRCW);
    sel_hi    = is_step2 ^ shift_r;
    a_byte    = sel_hi ? a_q[15:8] : a_q[7:0];
    b_byte    = sel_hi ? b_q[15:8] : b_q[7:0];
    step_cin  = is_logic ? 1'b0 : (is_step2 ? chain_c_q : (use_req_c & cin_q));
    step_inst = ALU_PASS0;
    case (op_q)
      OP_ADDW, OP_INCW: step_inst = is_step2 ? ALU_ADC : ALU_ADD;
      OP_ADCW:          step_inst = ALU_ADC;
      OP_SUBW, OP_DECW: step_inst = is_step2 ? ALU_SBC : ALU_SUB;
      OP_SBCW:          step_inst = ALU_SBC;
      OP_ANDW:          step_inst = ALU_AND;
      OP_ORW:           step_inst = ALU_OR;
      OP_XORW:          step_inst = ALU_XOR;
      OP_SLLW:          step_inst = is_step2 ? ALU_RLC : ALU_SLL;
      OP_RLCW:          step_inst = ALU_RLC;
      OP_SRLW:          step_inst = is_step2 ? ALU_RRC : ALU_SRL;
      OP_RRCW:          step_inst = ALU_RRC;
      default:          step_inst = ALU_PASS0;
    endcase
    merged_res = sel_hi ? {alu_result[7:0], res_q[7:0]}
                        : {res_q[15:8], alu_result[7:0]};
  end

  // Drive the ALU only during the two step states; park it otherwise
  always_comb begin
    alu_inst = ALU_PASS0;
    alu_op0  = 16'h0000;
    alu_op1  = 16'h0000;
    alu_c_in = 1'b0;
    if ((state_q == S_STEP1) || (state_q == S_STEP2)) begin
      alu_inst = step_inst;
      alu_op0  = {8'h00, a_byte};
      alu_op1  = is_shift ? 16'h0000 : {8'h00, b_byte};
      alu_c_in = step_cin;
    end
  end

  // Next-state, operand latch, byte capture and flag computation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    chain_c_d = chain_c_q;
    res_d     = res_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          // INCW/DECW are ADDW/SUBW with an implicit operand of one
          b_d   = ((req_op == OP_INCW) || (req_op == OP_DECW)) ? 16'h0001 : req_b;
          cin_d = req_c;
          if (req_op > OP_DECW) begin
            state_d = S_DONE;
            res_d   = 16'h0000;
            c_d     = 1'b0;
            z_d     = 1'b0;
            n_d     = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = S_STEP1;
            err_d   = 1'b0;
          end
        end
      end
      S_STEP1: begin
        res_d     = merged_res;
        chain_c_d = alu_c;
        state_d   = S_STEP2;
      end
      S_STEP2: begin
        res_d   = merged_res;
        c_d     = is_logic ? 1'b0 : alu_c;
        z_d     = (merged_res == 16'h0000);
        n_d     = merged_res[15];
        state_d = S_DONE;
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      cin_q     <= 1'b0;
      chain_c_q <= 1'b0;
      res_q     <= 16'h0000;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      chain_c_q <= chain_c_d;
      res_q     <= res_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      err_q     <= err_d;
    end
  end

  // Handshake and response outputs
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_DONE);
    rsp_result = res_q;
    rsp_c      = c_q;
    rsp_z      = z_q;
    rsp_n      = n_q;
    rsp_err    = err_q;
  end

endmodule
